// File: rtl/beepo_fetch.sv
// beepo_fetch: instruction-fetch unit for the beepo core.
// Owns the PC and drives the synchronous program ROM. Reads in flight are tracked
// by a ROM_LAT-deep tag pipe. Returned words land in a prefetch FIFO whose head
// is presented to decode over valid/ready. Supports redirect with flush, and halt.
// Optional feature: define BEEPO_FETCH_PERF_EN to add the o_perf_issued /
// o_perf_flushed saturating event counters.
module beepo_fetch #(
  parameter int INSTR_W    = 8,
  parameter int ADDR_W     = 8,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [ADDR_W-1:0]  o_rom_addr,
  output logic               o_rom_ce,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  input  logic               i_halt
`ifdef BEEPO_FETCH_PERF_EN
  ,
  output logic [31:0]        o_perf_issued,
  output logic [31:0]        o_perf_flushed
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic               epoch_q, epoch_d;

  logic               tag_valid_q [ROM_LAT];
  logic               tag_valid_d [ROM_LAT];
  logic [ADDR_W-1:0]  tag_pc_q    [ROM_LAT];
  logic [ADDR_W-1:0]  tag_pc_d    [ROM_LAT];
  logic               tag_epoch_q [ROM_LAT];
  logic               tag_epoch_d [ROM_LAT];

  logic [INSTR_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [INSTR_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_d   [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   inflight;
  logic [OCC_W-1:0]   occupancy;

  // Credit check: FIFO entries left after this cycle's pop plus reads in flight
  // must leave room for one more read, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + OCC_W'(tag_valid_q[i]);
    end
    pop       = (count_q != '0) && i_instr_ready;
    occupancy = OCC_W'(count_q) - OCC_W'(pop) + inflight;
    issue     = !i_halt && !i_redirect && (occupancy < OCC_W'(FIFO_DEPTH));
    push      = tag_valid_q[ROM_LAT-1] && (tag_epoch_q[ROM_LAT-1] == epoch_q) && !i_redirect;
  end

  // PC, last issued address, epoch and tag pipe next-state.
  always_comb begin
    pc_d        = pc_q;
    last_addr_d = last_addr_q;
    epoch_d     = epoch_q;
    tag_valid_d = tag_valid_q;
    tag_pc_d    = tag_pc_q;
    tag_epoch_d = tag_epoch_q;
    if (i_redirect) begin
      pc_d    = i_redirect_pc;
      epoch_d = ~epoch_q;
    end else if (issue) begin
      pc_d        = pc_q + ADDR_W'(1);
      last_addr_d = pc_q;
    end
    tag_valid_d[0] = issue;
    tag_pc_d[0]    = pc_q;
    tag_epoch_d[0] = epoch_q;
    // Redirect also clears older stages so back-to-back redirects that toggle the
    // epoch back cannot resurrect a stale read.
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1] && !i_redirect;
      tag_pc_d[i]    = tag_pc_q[i-1];
      tag_epoch_d[i] = tag_epoch_q[i-1];
    end
  end

  // Prefetch FIFO next-state: flush on redirect, otherwise push/pop.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (i_redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_data_d[wr_ptr_q] = i_rom_data;
        fifo_pc_d[wr_ptr_q]   = tag_pc_q[ROM_LAT-1];
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q        <= PC_RST;
      last_addr_q <= PC_RST;
      epoch_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_valid_q[i] <= 1'b0;
        tag_pc_q[i]    <= '0;
        tag_epoch_q[i] <= 1'b0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      last_addr_q <= last_addr_d;
      epoch_q     <= epoch_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      tag_valid_q <= tag_valid_d;
      tag_pc_q    <= tag_pc_d;
      tag_epoch_q <= tag_epoch_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

  // Reset masks the chip enable so nothing is issued while reset is held.
  assign o_rom_ce      = issue && i_rst_n;
  assign o_rom_addr    = o_rom_ce ? pc_q : last_addr_q;
  assign o_instr       = fifo_data_q[rd_ptr_q];
  assign o_instr_pc    = fifo_pc_q[rd_ptr_q];
  assign o_instr_valid = (count_q != '0);

`ifdef BEEPO_FETCH_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] flushed_sum;

  // Saturating counters: reads issued, and entries discarded by redirect.
  always_comb begin
    perf_issued_d = perf_issued_q;
    if (issue && (perf_issued_q != '1)) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    flushed_sum    = {1'b0, perf_flushed_q} + (i_redirect ? 33'(occupancy) : 33'd0);
    perf_flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
  end

  // Perf counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_issued_q  <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_issued_q  <= perf_issued_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign o_perf_issued  = perf_issued_q;
  assign o_perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_beepo_fetch.sv
// Bench for beepo_fetch: two instances (ROM latency 1 and 3) share stimulus.
// A per-instance reference keeps the stream of issued addresses since the last
// redirect as {head pc, outstanding count}; every delivery must be the head.
module tb_beepo_fetch;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic       redirect;
  logic       halt;
  logic [7:0] redirectPc;

  always #5 clk = ~clk;

  wire [7:0] romAddr0, romAddr1, romData0, romData1;
  wire [7:0] instr0, instr1, instrPc0, instrPc1;
  wire       romCe0, romCe1, valid0, valid1;
`ifdef BEEPO_FETCH_PERF_EN
  wire [31:0] perfIssued0, perfIssued1, perfFlushed0, perfFlushed1;
`endif

  function automatic logic [7:0] romWord(input logic [7:0] a);
    logic [7:0] m;
    m = a * 8'd37;
    return m ^ 8'hA5;
  endfunction

  // Synchronous ROM models with latency 1 and 3.
  logic [7:0] rom0Stage;
  logic [7:0] rom1Stage [3];
  always @(posedge clk) begin
    if (romCe0) rom0Stage <= romAddr0;
    if (romCe1) rom1Stage[0] <= romAddr1;
    rom1Stage[1] <= rom1Stage[0];
    rom1Stage[2] <= rom1Stage[1];
  end
  assign romData0 = romWord(rom0Stage);
  assign romData1 = romWord(rom1Stage[2]);

  beepo_fetch #(.INSTR_W(8), .ADDR_W(8), .ROM_LAT(1), .FIFO_DEPTH(DEPTH), .RESET_PC(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_rom_addr(romAddr0), .o_rom_ce(romCe0),
    .i_rom_data(romData0), .o_instr(instr0), .o_instr_pc(instrPc0),
    .o_instr_valid(valid0), .i_instr_ready(ready), .i_redirect(redirect),
    .i_redirect_pc(redirectPc), .i_halt(halt)
`ifdef BEEPO_FETCH_PERF_EN
    , .o_perf_issued(perfIssued0), .o_perf_flushed(perfFlushed0)
`endif
  );

  beepo_fetch #(.INSTR_W(8), .ADDR_W(8), .ROM_LAT(3), .FIFO_DEPTH(DEPTH), .RESET_PC(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_rom_addr(romAddr1), .o_rom_ce(romCe1),
    .i_rom_data(romData1), .o_instr(instr1), .o_instr_pc(instrPc1),
    .o_instr_valid(valid1), .i_instr_ready(ready), .i_redirect(redirect),
    .i_redirect_pc(redirectPc), .i_halt(halt)
`ifdef BEEPO_FETCH_PERF_EN
    , .o_perf_issued(perfIssued1), .o_perf_flushed(perfFlushed1)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc;
  int romLat [2] = '{1, 3};
  logic [7:0] issuePc [2];
  logic [7:0] headPc [2];
  logic [7:0] lastAddr [2];
  int outst [2];
  int issues [2];
  int accepts [2];
  int firstValid [2];
  int outstAtHalt [2];
  logic lastValid [2];
  logic lastCe [2];
  longint perfIss [2];
  longint perfFl [2];
  logic [7:0] capPc [4];
  int capN;
  bit capOn;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      issuePc[d] = 8'h00; headPc[d] = 8'h00; lastAddr[d] = 8'h00;
      outst[d] = 0; issues[d] = 0; accepts[d] = 0; firstValid[d] = -1;
      perfIss[d] = 0; perfFl[d] = 0;
    end
    cyc = 0;
  endtask

  task automatic checkReset();
    checkOutput("rst_ce0", 32'(romCe0), 32'd0);
    checkOutput("rst_addr0", 32'(romAddr0), 32'd0);
    checkOutput("rst_valid0", 32'(valid0), 32'd0);
    checkOutput("rst_instr0", 32'(instr0), 32'd0);
    checkOutput("rst_pc0", 32'(instrPc0), 32'd0);
    checkOutput("rst_ce1", 32'(romCe1), 32'd0);
    checkOutput("rst_addr1", 32'(romAddr1), 32'd0);
    checkOutput("rst_valid1", 32'(valid1), 32'd0);
    checkOutput("rst_instr1", 32'(instr1), 32'd0);
    checkOutput("rst_pc1", 32'(instrPc1), 32'd0);
  endtask

  // Compare one instance against the reference for the current cycle.
  task automatic observe(input int d);
    logic ce, v;
    logic [7:0] addr, ipc, ins;
    ce   = (d == 0) ? romCe0 : romCe1;
    v    = (d == 0) ? valid0 : valid1;
    addr = (d == 0) ? romAddr0 : romAddr1;
    ipc  = (d == 0) ? instrPc0 : instrPc1;
    ins  = (d == 0) ? instr0 : instr1;
    lastValid[d] = v;
    lastCe[d] = ce;
    if (v) begin
      checkOutput("valid_has_pending", 32'(outst[d] > 0), 32'd1);
      if (firstValid[d] < 0) firstValid[d] = cyc;
    end
    if (v && ready) begin
      checkOutput("deliver_pc", 32'(ipc), 32'(headPc[d]));
      checkOutput("deliver_instr", 32'(ins), 32'(romWord(headPc[d])));
      if (capOn && d == 0 && capN < 4) begin
        capPc[capN] = ipc;
        capN++;
      end
      headPc[d] = headPc[d] + 8'd1;
      outst[d]--;
      accepts[d]++;
    end
    if (ce) begin
      checkOutput("issue_addr", 32'(addr), 32'(issuePc[d]));
      checkOutput("issue_allowed", 32'({halt, redirect}), 32'd0);
      checkOutput("credit", 32'(outst[d] < DEPTH), 32'd1);
      lastAddr[d] = issuePc[d];
      issuePc[d] = issuePc[d] + 8'd1;
      outst[d]++;
      issues[d]++;
      perfIss[d]++;
    end else begin
      checkOutput("addr_hold", 32'(addr), 32'(lastAddr[d]));
    end
    if (redirect) begin
      perfFl[d] += longint'(outst[d]);
      outst[d] = 0;
      issuePc[d] = redirectPc;
      headPc[d] = redirectPc;
    end
  endtask

  // Advance one clock: sample at the falling edge, inputs change 1 after rising edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst_n) begin
        observe(0);
        observe(1);
        cyc++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(2);
    checkReset();
    resetModel();
    rst_n = 1'b1;
  endtask

  task automatic pulseRedirect(input logic [7:0] target);
    redirect = 1'b1;
    redirectPc = target;
    applyStimulus(1);
    redirect = 1'b0;
    capOn = 1'b1;
    capN = 0;
  endtask

`ifdef BEEPO_FETCH_PERF_EN
  task automatic checkPerf();
    checkOutput("perf_issued0", perfIssued0, 32'(perfIss[0]));
    checkOutput("perf_issued1", perfIssued1, 32'(perfIss[1]));
    checkOutput("perf_flushed0", perfFlushed0, 32'(perfFl[0]));
    checkOutput("perf_flushed1", perfFlushed1, 32'(perfFl[1]));
  endtask
`endif

  initial begin
    ready = 1'b1; redirect = 1'b0; halt = 1'b0; redirectPc = 8'h00;
    capOn = 1'b0; capN = 0;
    rst_n = 1'b0;
    #1;
    resetModel();

    $display("[TB] reset release, streaming");
    doReset();
    applyStimulus(8);
    for (int d = 0; d < 2; d++) checkOutput("first_valid_cycle", 32'(firstValid[d]), 32'(romLat[d] + 1));
    accepts[0] = 0; accepts[1] = 0;
    applyStimulus(20);
    for (int d = 0; d < 2; d++) checkOutput("throughput", 32'(accepts[d]), 32'd20);

    $display("[TB] decode stall");
    ready = 1'b0;
    doReset();
    applyStimulus(10);
    for (int d = 0; d < 2; d++) begin
      checkOutput("stall_issues", 32'(issues[d]), 32'(DEPTH));
      checkOutput("stall_ce_low", 32'(lastCe[d]), 32'd0);
    end
    ready = 1'b1;
    accepts[0] = 0; accepts[1] = 0;
    applyStimulus(10);
    for (int d = 0; d < 2; d++) checkOutput("stall_resume", 32'(accepts[d]), 32'd10);

    $display("[TB] pc wrap");
    pulseRedirect(8'hFE);
    applyStimulus(8);
    checkOutput("wrap_n", 32'(capN), 32'd4);
    checkOutput("wrap_0", 32'(capPc[0]), 32'hFE);
    checkOutput("wrap_1", 32'(capPc[1]), 32'hFF);
    checkOutput("wrap_2", 32'(capPc[2]), 32'h00);
    checkOutput("wrap_3", 32'(capPc[3]), 32'h01);

    $display("[TB] redirect with data in flight");
    ready = 1'b0;
    applyStimulus(2);
    pulseRedirect(8'h40);
    ready = 1'b1;
    applyStimulus(8);
    checkOutput("redir_first", 32'(capPc[0]), 32'h40);
`ifdef BEEPO_FETCH_PERF_EN
    checkPerf();
`endif

    $display("[TB] halt");
    applyStimulus(10);
    halt = 1'b1;
    for (int d = 0; d < 2; d++) begin
      outstAtHalt[d] = outst[d];
      accepts[d] = 0;
      issues[d] = 0;
    end
    applyStimulus(8);
    for (int d = 0; d < 2; d++) begin
      checkOutput("halt_drain", 32'(accepts[d]), 32'(outstAtHalt[d]));
      checkOutput("halt_empty", 32'(lastValid[d]), 32'd0);
    end
    pulseRedirect(8'h80);
    applyStimulus(3);
    for (int d = 0; d < 2; d++) checkOutput("halt_no_issue", 32'(issues[d]), 32'd0);
    halt = 1'b0;
    applyStimulus(8);
    checkOutput("halt_redir_first", 32'(capPc[0]), 32'h80);

    $display("[TB] random traffic");
    capOn = 1'b0;
    for (int n = 0; n < 400; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      redirect = ($urandom_range(0, 19) == 0);
      redirectPc = 8'($urandom);
      applyStimulus(1);
    end
    redirect = 1'b0;
    halt = 1'b0;
    ready = 1'b1;
    applyStimulus(10);
`ifdef BEEPO_FETCH_PERF_EN
    checkPerf();
`endif

    $display("[TB] async reset mid-stream");
    #2;
    rst_n = 1'b0;
    #1;
    checkReset();
    @(posedge clk);
    #1;
    applyStimulus(1);
    resetModel();
    rst_n = 1'b1;
    applyStimulus(8);
    for (int d = 0; d < 2; d++) checkOutput("restart_first_valid", 32'(firstValid[d]), 32'(romLat[d] + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
